// File: rtl/stream_output_handler.sv
// stream_output_handler: packs hit and end-of-query records two per 128-bit word
// into a first-word-fall-through FIFO drained by the host over a valid/ready port.
module stream_output_handler #(
  parameter int NUM_PES      = 64,
  parameter int WIDTH        = 10,
  parameter int FIFO_DEPTH   = 16,
  parameter int FLUSH_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_valid,
  output logic             hit_rdy,
  input  logic [15:0]      hit_query_id,
  input  logic [24:0]      hit_ref_block,
  input  logic [6:0]       hit_pe_idx,
  input  logic [WIDTH-1:0] hit_score,
  input  logic             eoq_valid,
  output logic             eoq_rdy,
  input  logic [15:0]      eoq_query_id,
  output logic             so_valid,
  output logic [127:0]     so_data,
  input  logic             so_rdy,
  output logic [31:0]      words_sent
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(FLUSH_CYCLES + 1);
  logic [127:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          full_q, full_d, lo_valid_q, lo_valid_d;
  logic [63:0]   lo_q, lo_d, hit_rec, eoq_rec;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   words_sent_q, words_sent_d;
  logic          hit_acc, eoq_acc, flush, push, pop, empty, timer_done;
  logic [127:0]  push_data;
  assign empty      = count_q == '0;
  assign hit_rdy    = rst & ~full_q;
  assign eoq_rdy    = rst & ~full_q & ~hit_valid;
  assign hit_acc    = hit_valid & hit_rdy;
  assign eoq_acc    = eoq_valid & eoq_rdy;
  assign timer_done = timer_q == TW'(FLUSH_CYCLES - 1);
  // an accepted record always pairs with lo, so it supersedes a due flush
  assign flush      = rst & lo_valid_q & ~hit_acc & ~eoq_acc & ~full_q & timer_done;
  assign push       = (hit_acc & lo_valid_q) | eoq_acc | flush;
  assign so_valid   = ~empty;
  assign pop        = so_valid & so_rdy;
  assign so_data    = empty ? '0 : mem_q[rd_ptr_q];
  assign words_sent = words_sent_q;
  assign hit_rec    = {2'b01, hit_query_id, hit_ref_block, hit_pe_idx, 14'(hit_score)};
  assign eoq_rec    = {2'b10, eoq_query_id, 46'd0};
  always_comb begin
    push_data    = hit_acc ? {hit_rec, lo_q}
                 : eoq_acc ? (lo_valid_q ? {eoq_rec, lo_q} : {64'd0, eoq_rec})
                 : {64'd0, lo_q};
    lo_d         = (hit_acc & ~lo_valid_q) ? hit_rec : lo_q;
    lo_valid_d   = hit_acc ? ~lo_valid_q : (eoq_acc | flush) ? 1'b0 : lo_valid_q;
    timer_d      = (hit_acc | eoq_acc | flush | ~lo_valid_q) ? '0
                 : timer_done ? timer_q : timer_q + TW'(1);
    wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d      = count_q + (PW+1)'(push) - (PW+1)'(pop);
    full_d       = count_d == (PW+1)'(FIFO_DEPTH);
    words_sent_d = words_sent_q + 32'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      lo_valid_q   <= 1'b0;
      lo_q         <= '0;
      timer_q      <= '0;
      words_sent_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      lo_valid_q   <= lo_valid_d;
      lo_q         <= lo_d;
      timer_q      <= timer_d;
      words_sent_q <= words_sent_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end
  a_pe_range: assert property (@(posedge clk) disable iff (!rst)
    hit_valid |-> 32'(hit_pe_idx) < NUM_PES);
endmodule

// File: tb/tb_stream_output_handler.sv
// tb_stream_output_handler: directed and randomized stimulus checked every cycle
// against a queue-based model of record packing, flushing and host draining.
module tb_stream_output_handler;
  localparam int D = 16, F = 4, W = 10;
  logic clk = 0, rst = 0, hit_valid = 0, eoq_valid = 0, so_rdy = 0;
  logic [15:0] hit_query_id = 0, eoq_query_id = 0;
  logic [24:0] hit_ref_block = 0;
  logic [6:0] hit_pe_idx = 0;
  logic [W-1:0] hit_score = 0;
  logic hit_rdy, eoq_rdy, so_valid;
  logic [127:0] so_data;
  logic [31:0] words_sent;
  int nvec = 0, nerr = 0;
  bit live = 0;
  logic [127:0] exp_q[$];
  logic [63:0] pend = 0;
  bit pend_v = 0;
  int idle = 0;
  logic [31:0] sent = 0;

  always #5 clk = ~clk;

  stream_output_handler #(.NUM_PES(64), .WIDTH(W), .FIFO_DEPTH(D), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst(rst), .hit_valid(hit_valid), .hit_rdy(hit_rdy),
    .hit_query_id(hit_query_id), .hit_ref_block(hit_ref_block), .hit_pe_idx(hit_pe_idx),
    .hit_score(hit_score), .eoq_valid(eoq_valid), .eoq_rdy(eoq_rdy),
    .eoq_query_id(eoq_query_id), .so_valid(so_valid), .so_data(so_data),
    .so_rdy(so_rdy), .words_sent(words_sent));

  function automatic logic [63:0] hrec(input logic [15:0] q, input logic [24:0] b,
                                       input logic [6:0] p, input logic [W-1:0] s);
    return {2'b01, q, b, p, 14'(s)};
  endfunction

  function automatic logic [63:0] erec(input logic [15:0] q);
    return {2'b10, q, 46'd0};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a word is emitted when a second record arrives, an eoq arrives,
  // or a lone record has waited F idle cycles with room in the FIFO.
  always @(posedge clk) begin
    bit full, hacc, eacc;
    if (!rst) begin
      exp_q.delete();
      pend_v = 0;
      idle = 0;
      sent = 0;
    end else begin
      full = exp_q.size() == D;
      hacc = hit_valid && !full;
      eacc = eoq_valid && !full && !hit_valid;
      if (so_rdy && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        sent++;
      end
      if (hacc) begin
        if (pend_v) exp_q.push_back({hrec(hit_query_id, hit_ref_block, hit_pe_idx, hit_score), pend});
        else pend = hrec(hit_query_id, hit_ref_block, hit_pe_idx, hit_score);
        pend_v = !pend_v;
        idle = 0;
      end else if (eacc) begin
        exp_q.push_back(pend_v ? {erec(eoq_query_id), pend} : {64'd0, erec(eoq_query_id)});
        pend_v = 0;
        idle = 0;
      end else if (pend_v) begin
        idle++;
        if (idle >= F && !full) begin
          exp_q.push_back({64'd0, pend});
          pend_v = 0;
          idle = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("hit_rdy", hit_rdy, rst && exp_q.size() < D);
      chk("eoq_rdy", eoq_rdy, rst && exp_q.size() < D && !hit_valid);
      chk("so_valid", so_valid, exp_q.size() > 0);
      chk("so_data", so_data, exp_q.size() > 0 ? exp_q[0] : 128'd0);
      chk("words_sent", words_sent, sent);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hit(input logic [15:0] q, input logic [24:0] b,
                          input logic [6:0] p, input logic [W-1:0] s);
    bit acc;
    int g;
    g = 0;
    hit_query_id = q; hit_ref_block = b; hit_pe_idx = p; hit_score = s;
    hit_valid = 1;
    do begin
      @(negedge clk);
      acc = hit_rdy;
      step();
      g++;
    end while (!acc && g < 200);
    if (!acc) begin
      nvec++; nerr++;
      $display("FAIL hit_accept_timeout: got rdy 0 expected 1 within 200 cycles");
    end
    hit_valid = 0;
  endtask

  task automatic send_eoq(input logic [15:0] q);
    bit acc;
    int g;
    g = 0;
    eoq_query_id = q;
    eoq_valid = 1;
    do begin
      @(negedge clk);
      acc = eoq_rdy;
      step();
      g++;
    end while (!acc && g < 200);
    if (!acc) begin
      nvec++; nerr++;
      $display("FAIL eoq_accept_timeout: got rdy 0 expected 1 within 200 cycles");
    end
    eoq_valid = 0;
  endtask

  initial begin
    logic [127:0] held;
    step();
    live = 1;
    @(negedge clk);
    chk("reset_so_valid", so_valid, 0);
    chk("reset_hit_rdy", hit_rdy, 0);
    chk("reset_words_sent", words_sent, 0);
    step();
    rst = 1;
    so_rdy = 1;
    // two hits pack into one word
    send_hit(5, 3, 1, 9);
    send_hit(5, 3, 2, 12);
    @(negedge clk);
    chk("t1_valid", so_valid, 1);
    chk("t1_word", so_data, 128'h4001_4000_0060_800C_4001_4000_0060_4009);
    step();
    @(negedge clk);
    chk("t1_sent", words_sent, 1);
    step();
    // hit then eoq
    send_hit(5, 3, 1, 9);
    send_eoq(5);
    @(negedge clk);
    chk("t2_word", so_data, 128'h8001_4000_0000_0000_4001_4000_0060_4009);
    step();
    // lone eoq, then a hit/eoq collision
    send_eoq(7);
    @(negedge clk);
    chk("t3_lone_eoq", so_data, 128'h0000_0000_0000_0000_8001_C000_0000_0000);
    step();
    hit_query_id = 5; hit_ref_block = 3; hit_pe_idx = 1; hit_score = 9;
    hit_valid = 1; eoq_query_id = 7; eoq_valid = 1;
    @(negedge clk);
    chk("t3_coll_hit_rdy", hit_rdy, 1);
    chk("t3_coll_eoq_rdy", eoq_rdy, 0);
    step();
    hit_valid = 0;
    @(negedge clk);
    chk("t3_eoq_rdy_next", eoq_rdy, 1);
    step();
    eoq_valid = 0;
    @(negedge clk);
    chk("t3_pair_word", so_data, 128'h8001_C000_0000_0000_4001_4000_0060_4009);
    step();
    // flush after F idle cycles
    send_hit(9, 1, 3, 5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t4_quiet", so_valid, 0);
      step();
    end
    @(negedge clk);
    chk("t4_flush_valid", so_valid, 1);
    chk("t4_flush_word", so_data, 128'h0000_0000_0000_0000_4002_4000_0020_C005);
    step();
    // a second hit before the timer expires pairs instead of flushing
    send_hit(9, 1, 3, 5);
    step();
    step();
    send_hit(9, 1, 4, 6);
    @(negedge clk);
    chk("t4_pair_word", so_data, 128'h4002_4000_0021_0006_4002_4000_0020_C005);
    step();
    step();
    // fill the FIFO under backpressure
    so_rdy = 0;
    for (int i = 0; i < 2 * D; i++)
      send_hit(16'($urandom), 25'($urandom), 7'($urandom_range(0, 63)), W'($urandom));
    @(negedge clk);
    chk("t5_full_rdy", hit_rdy, 0);
    held = so_data;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("t5_held", so_data, held);
    end
    step();
    so_rdy = 1;
    @(negedge clk);
    chk("t5_rdy_pop_cycle", hit_rdy, 0);
    step();
    @(negedge clk);
    chk("t5_rdy_recover", hit_rdy, 1);
    step();
    repeat (20) step();
    // reset with queued words and a pending record
    so_rdy = 0;
    for (int i = 0; i < 7; i++) send_hit(16'(i), 25'(i), 7'(i), W'(i));
    rst = 0;
    step();
    @(negedge clk);
    chk("t6_so_valid", so_valid, 0);
    chk("t6_so_data", so_data, 0);
    chk("t6_sent", words_sent, 0);
    chk("t6_hit_rdy", hit_rdy, 0);
    step();
    rst = 1;
    so_rdy = 1;
    repeat (8) step();
    @(negedge clk);
    chk("t6_no_stale", so_valid, 0);
    step();
    // randomized traffic with backpressure phases and occasional reset
    for (int i = 0; i < 3000; i++) begin
      hit_valid = $urandom_range(0, 99) < (((i / 500) % 2 == 1) ? 70 : 25);
      eoq_valid = $urandom_range(0, 99) < 20;
      so_rdy = $urandom_range(0, 99) < (((i / 300) % 3 == 0) ? 10 : 60);
      hit_query_id = 16'($urandom);
      hit_ref_block = 25'($urandom);
      hit_pe_idx = 7'($urandom_range(0, 63));
      hit_score = W'($urandom);
      eoq_query_id = 16'($urandom);
      rst = (i % 997) != 500;
      step();
    end
    hit_valid = 0;
    eoq_valid = 0;
    rst = 1;
    so_rdy = 1;
    repeat (60) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
